taxi_sfp_mod_mon: RTL
=====================

Name: taxi_sfp_mod_mon

Overview:
- Per-cage SFP+ module supervisor for the NIC board cores.
- Sits between the raw cage pins (npres, tx_fault, los) plus the MAC rx_status, and the board GPIO (cage LEDs, TX disable).
- Synchronizes and debounces the cage pins, then runs a per-port link-state FSM.
- Drives sfp_tx_disable during module insertion and fault recovery, generates solid or blinking LED patterns, and reports state plus change-event pulses for management logic.

Parameters:
- CNT, 2, number of SFP cages.
- DEBOUNCE_CYCLES, 125000, cycles an input must hold a new level before it is accepted (1 ms at 125 MHz); must be >= 2.
- SETTLE_CYCLES, 62500000, cycles tx_disable stays high after insertion or fault clear (0.5 s); must be >= 1.
- BLINK_FAST, 7812500, half-period of the fast blink in cycles (8 Hz).
- BLINK_SLOW, 31250000, half-period of the slow blink in cycles (2 Hz).

Ports:
- clk  in  1  module clock (clk_125mhz domain).
- rst  in  1  reset: synchronous, active-high.
- sfp_npres  in  [CNT]  module not-present, asynchronous.
- sfp_tx_fault  in  [CNT]  module TX fault, asynchronous.
- sfp_los  in  [CNT]  loss of signal, asynchronous.
- rx_status  in  [CNT]  MAC receive link status from the rx_clk domain; synchronized here, not debounced.
- sfp_tx_disable  out  [CNT]  module TX disable, active-high.
- sfp_led  out  [CNT]  cage LED, active-high; the board top applies any pin inversion.
- port_state  out  [CNT][2:0]  current FSM state encoding.
- state_change  out  [CNT]  single-cycle pulse on any port_state change.

Behaviour:
- Reset is synchronous and active-high. While rst is high and on the first edge after it falls:
  - all outputs are registered;
  - sfp_tx_disable = 1, sfp_led = 0, port_state = ABSENT (0), state_change = 0.
  - synchronizer and debounced values take the inactive levels: npres = 1, fault = 0, los = 1, rx_status = 0.
  - all counters clear.
- Synchronizers: 2-flop chain per input bit, no other logic in the chain.
- Debounce, per bit:
  - if sync == deb, the counter clears;
  - else the counter increments, and when it equals DEBOUNCE_CYCLES-1, deb <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles is never accepted.
  - Stable pin change to port_state update = DEBOUNCE_CYCLES+3 cycles.
- FSM states: ABSENT = 0, SETTLE = 1, FAULT = 2, NO_SIGNAL = 3, LINK_DOWN = 4, LINK_UP = 5; codes 6 and 7 go to ABSENT.
- Global rule, highest priority: if deb_npres == 1 from any state, go to ABSENT.
- ABSENT: if deb_npres == 0, go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
- SETTLE: decrement the counter; at 0, evaluate.
- Evaluate, in priority order:
  - deb_fault -> FAULT;
  - deb_los -> NO_SIGNAL;
  - !rx_status_sync -> LINK_DOWN;
  - otherwise -> LINK_UP.
- FAULT: on deb_fault == 0, go to SETTLE (retry with a tx_disable pulse); the counter reloads.
- NO_SIGNAL, LINK_DOWN, LINK_UP: re-evaluate every cycle with the same priority. Any simultaneous conditions resolve by that priority.
- sfp_tx_disable: 1 in ABSENT, SETTLE and FAULT; 0 otherwise. Registered together with the state.
- LED, registered with the state:
  - ABSENT, SETTLE, NO_SIGNAL: 0;
  - FAULT: fast blink phase;
  - LINK_DOWN: slow blink phase;
  - LINK_UP: 1.
- Blink generators: two free-running counters shared by all ports.
  - Each phase bit toggles when its counter reaches the half-period minus 1, then the counter wraps to 0.
  - Phases start at 0 after reset, so the first blink-on arrives BLINK_x cycles after reset release.
- state_change[i] = 1 for exactly one cycle, registered, on the cycle after port_state[i] takes a new value. Back-to-back changes give back-to-back pulses.
- Ports are fully independent apart from the shared blink generators.
- Reset mid-settle or mid-debounce: all progress is discarded and the block starts again from the reset values.

Test Plan (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=8, BLINK_FAST=2, BLINK_SLOW=8, CNT=2):
- After reset, npres=1 on both ports, 20 cycles -> port_state=0, tx_disable=1, led=0, state_change never asserted.
- Port 0: npres falls with los=0, fault=0, rx_status=1:
  - port_state goes to 1 exactly 7 cycles after the pin edge, with a single state_change pulse;
  - 8 cycles later port_state=5, tx_disable=0, led=1.
- In LINK_UP, pulse npres high for 3 cycles -> no state change. Then hold npres high 10 cycles -> ABSENT, tx_disable=1, led=0.
- Assert fault during LINK_UP:
  - FAULT with led toggling every 2 cycles and tx_disable=1;
  - release fault -> SETTLE for 8 cycles -> LINK_UP.
- Drop rx_status with los=0 -> LINK_DOWN, led toggling every 8 cycles. Raise los simultaneously with rx_status drop -> NO_SIGNAL (priority), led=0.
- Assert rst for 1 cycle in the middle of SETTLE on port 1 -> all outputs return to reset values on the next edge. Port 0 state is unaffected by port 1 pin activity in all scenarios.

Source files
------------

// File: rtl/taxi_sfp_mod_mon.sv
// Per-cage SFP+ supervisor: synchronizes and debounces the cage pins, runs a link-state
// FSM per port and drives TX disable, the cage LED, state reporting and change pulses.
module taxi_sfp_mod_mon #(
  parameter int CNT             = 2,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int SETTLE_CYCLES   = 62500000,
  parameter int BLINK_FAST      = 7812500,
  parameter int BLINK_SLOW      = 31250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT-1:0]       sfp_npres,
  input  logic [CNT-1:0]       sfp_tx_fault,
  input  logic [CNT-1:0]       sfp_los,
  input  logic [CNT-1:0]       rx_status,
  output logic [CNT-1:0]       sfp_tx_disable,
  output logic [CNT-1:0]       sfp_led,
  output logic [CNT-1:0][2:0]  port_state,
  output logic [CNT-1:0]       state_change
);

  typedef enum logic [2:0] {
    ST_ABSENT    = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_FAULT     = 3'd2,
    ST_NO_SIGNAL = 3'd3,
    ST_LINK_DOWN = 3'd4,
    ST_LINK_UP   = 3'd5
  } state_t;

  localparam int NB  = 3 * CNT;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int FW  = $clog2(BLINK_FAST + 1);
  localparam int LW  = $clog2(BLINK_SLOW + 1);

  localparam logic [DBW-1:0] DEB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0]  FAST_LAST   = FW'(BLINK_FAST - 1);
  localparam logic [LW-1:0]  SLOW_LAST   = LW'(BLINK_SLOW - 1);

  // Pin vector layout {los, fault, npres}; idle levels are los=1, fault=0, npres=1.
  localparam logic [NB-1:0]  PIN_IDLE = {{CNT{1'b1}}, {CNT{1'b0}}, {CNT{1'b1}}};

  logic [NB-1:0]       pin_raw;
  logic [NB-1:0]       sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
  logic [DBW-1:0]      dcnt_q [NB];
  logic [DBW-1:0]      dcnt_d [NB];
  logic [CNT-1:0]      rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [FW-1:0]       fast_cnt_q, fast_cnt_d;
  logic [LW-1:0]       slow_cnt_q, slow_cnt_d;
  logic                fast_ph_q, fast_ph_d, slow_ph_q, slow_ph_d;
  logic [CNT-1:0][2:0] state_q, state_d;
  logic [SW-1:0]       scnt_q [CNT];
  logic [SW-1:0]       scnt_d [CNT];
  logic [CNT-1:0]      txdis_q, txdis_d, led_q, led_d;
  logic [CNT-1:0]      chg_pend_q, chg_pend_d, chg_q, chg_d;

  function automatic state_t link_eval(input logic fault, input logic los, input logic rx);
    if (fault)    return ST_FAULT;
    else if (los) return ST_NO_SIGNAL;
    else if (!rx) return ST_LINK_DOWN;
    else          return ST_LINK_UP;
  endfunction

  assign pin_raw = {sfp_los, sfp_tx_fault, sfp_npres};

  always_comb begin
    sync1_d    = pin_raw;
    sync2_d    = sync1_q;
    rx_s1_d    = rx_status;
    rx_s2_d    = rx_s1_q;
    deb_d      = deb_q;
    dcnt_d     = dcnt_q;
    fast_cnt_d = fast_cnt_q;
    fast_ph_d  = fast_ph_q;
    slow_cnt_d = slow_cnt_q;
    slow_ph_d  = slow_ph_q;
    state_d    = state_q;
    scnt_d     = scnt_q;
    txdis_d    = txdis_q;
    led_d      = led_q;
    chg_pend_d = '0;
    chg_d      = chg_pend_q;

    for (int k = 0; k < NB; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        dcnt_d[k] = '0;
      end else if (dcnt_q[k] == DEB_LAST) begin
        deb_d[k]  = sync2_q[k];
        dcnt_d[k] = '0;
      end else begin
        dcnt_d[k] = dcnt_q[k] + DBW'(1);
      end
    end

    if (fast_cnt_q == FAST_LAST) begin
      fast_cnt_d = '0;
      fast_ph_d  = ~fast_ph_q;
    end else begin
      fast_cnt_d = fast_cnt_q + FW'(1);
    end
    if (slow_cnt_q == SLOW_LAST) begin
      slow_cnt_d = '0;
      slow_ph_d  = ~slow_ph_q;
    end else begin
      slow_cnt_d = slow_cnt_q + LW'(1);
    end

    for (int i = 0; i < CNT; i++) begin
      // Module removal overrides everything else.
      if (deb_q[i]) begin
        state_d[i] = ST_ABSENT;
      end else begin
        case (state_t'(state_q[i]))
          ST_ABSENT: begin
            state_d[i] = ST_SETTLE;
            scnt_d[i]  = SETTLE_LOAD;
          end
          ST_SETTLE: begin
            if (scnt_q[i] == '0) state_d[i] = link_eval(deb_q[CNT+i], deb_q[2*CNT+i], rx_s2_q[i]);
            else                 scnt_d[i]  = scnt_q[i] - SW'(1);
          end
          ST_FAULT: begin
            if (!deb_q[CNT+i]) begin
              state_d[i] = ST_SETTLE;
              scnt_d[i]  = SETTLE_LOAD;
            end
          end
          ST_NO_SIGNAL, ST_LINK_DOWN, ST_LINK_UP: begin
            state_d[i] = link_eval(deb_q[CNT+i], deb_q[2*CNT+i], rx_s2_q[i]);
          end
          default: state_d[i] = ST_ABSENT;
        endcase
      end

      txdis_d[i] = (state_d[i] == ST_ABSENT) || (state_d[i] == ST_SETTLE) ||
                   (state_d[i] == ST_FAULT);
      case (state_t'(state_d[i]))
        ST_FAULT:     led_d[i] = fast_ph_q;
        ST_LINK_DOWN: led_d[i] = slow_ph_q;
        ST_LINK_UP:   led_d[i] = 1'b1;
        default:      led_d[i] = 1'b0;
      endcase
      chg_pend_d[i] = (state_d[i] != state_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= PIN_IDLE;
      sync2_q    <= PIN_IDLE;
      deb_q      <= PIN_IDLE;
      for (int k = 0; k < NB; k++) dcnt_q[k] <= '0;
      rx_s1_q    <= '0;
      rx_s2_q    <= '0;
      fast_cnt_q <= '0;
      fast_ph_q  <= 1'b0;
      slow_cnt_q <= '0;
      slow_ph_q  <= 1'b0;
      state_q    <= '0;
      for (int i = 0; i < CNT; i++) scnt_q[i] <= '0;
      txdis_q    <= '1;
      led_q      <= '0;
      chg_pend_q <= '0;
      chg_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      dcnt_q     <= dcnt_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      fast_cnt_q <= fast_cnt_d;
      fast_ph_q  <= fast_ph_d;
      slow_cnt_q <= slow_cnt_d;
      slow_ph_q  <= slow_ph_d;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      txdis_q    <= txdis_d;
      led_q      <= led_d;
      chg_pend_q <= chg_pend_d;
      chg_q      <= chg_d;
    end
  end

  assign sfp_tx_disable = txdis_q;
  assign sfp_led        = led_q;
  assign port_state     = state_q;
  assign state_change   = chg_q;

endmodule
